// File: rtl/sys_arr_tile_if.sv
// rtl/sys_arr_tile_if.sv - operand beat stream into the systolic tile
interface sys_arr_tile_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [ROWS*DW-1:0]   a_in;
  logic [COLS*DW-1:0]   b_in;

  modport master (
    output in_valid, in_last, a_in, b_in,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, a_in, b_in,
    output in_ready
  );
endinterface

// File: rtl/sys_arr_tile.sv
// rtl/sys_arr_tile.sv - ROWS x COLS output-stationary systolic MAC tile
module sys_arr_tile #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DW    = 16,
  parameter int ACC_W = 32,
  parameter int IW    = (ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               acc_keep,
  sys_arr_tile_if.slave      stream,
  output logic               busy,
  output logic               done,
  input  logic [IW-1:0]      rd_index,
  output logic [ACC_W-1:0]   rd_data
);

  localparam int N    = ROWS * COLS;
  localparam int CW   = $clog2(ROWS + COLS) + 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(ROWS + COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   drain_cnt;
  logic            accept;
  logic            clear_acc;

  logic [DW-1:0]   a_head_d [ROWS];
  logic            a_head_v [ROWS];
  logic [DW-1:0]   b_head_d [COLS];
  logic            b_head_v [COLS];

  logic [DW-1:0]   a_pd [ROWS][COLS];
  logic            a_pv [ROWS][COLS];
  logic [DW-1:0]   b_pd [ROWS][COLS];
  logic            b_pv [ROWS][COLS];

  logic signed [2*DW-1:0] mul [ROWS][COLS];
  logic [ACC_W-1:0]       acc [N];

  assign stream.in_ready = (state == S_RUN);
  assign busy            = (state == S_RUN) || (state == S_DRAIN);
  assign done            = (state == S_DONE);
  assign accept          = stream.in_valid && stream.in_ready;
  assign clear_acc       = start && !acc_keep && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (accept && stream.in_last) state_next = S_DRAIN;
      S_DRAIN: if (drain_cnt == DRAIN_LAST) state_next = S_DONE;
      S_DONE:  if (start) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_cnt <= '0;
    end else if (accept && stream.in_last) begin
      drain_cnt <= '0;
    end else if (state == S_DRAIN) begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Row r of A waits r cycles before entering column 0 of the array.
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    if (r == 0) begin : g_direct
      assign a_head_d[r] = stream.a_in[r*DW +: DW];
      assign a_head_v[r] = accept;
    end else begin : g_delay
      logic [DW-1:0] sk_d [r];
      logic          sk_v [r];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < r; i++) begin
            sk_d[i] <= '0;
            sk_v[i] <= 1'b0;
          end
        end else begin
          sk_d[0] <= stream.a_in[r*DW +: DW];
          sk_v[0] <= accept;
          for (int i = 1; i < r; i++) begin
            sk_d[i] <= sk_d[i-1];
            sk_v[i] <= sk_v[i-1];
          end
        end
      end
      assign a_head_d[r] = sk_d[r-1];
      assign a_head_v[r] = sk_v[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    if (c == 0) begin : g_direct
      assign b_head_d[c] = stream.b_in[c*DW +: DW];
      assign b_head_v[c] = accept;
    end else begin : g_delay
      logic [DW-1:0] sk_d [c];
      logic          sk_v [c];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < c; i++) begin
            sk_d[i] <= '0;
            sk_v[i] <= 1'b0;
          end
        end else begin
          sk_d[0] <= stream.b_in[c*DW +: DW];
          sk_v[0] <= accept;
          for (int i = 1; i < c; i++) begin
            sk_d[i] <= sk_d[i-1];
            sk_v[i] <= sk_v[i-1];
          end
        end
      end
      assign b_head_d[c] = sk_d[c-1];
      assign b_head_v[c] = sk_v[c-1];
    end
  end

  // Operand registers at each PE input: A hops right, B hops down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          a_pd[r][c] <= '0;
          a_pv[r][c] <= 1'b0;
          b_pd[r][c] <= '0;
          b_pv[r][c] <= 1'b0;
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (c == 0) begin
            a_pd[r][c] <= a_head_d[r];
            a_pv[r][c] <= a_head_v[r];
          end else begin
            a_pd[r][c] <= a_pd[r][c-1];
            a_pv[r][c] <= a_pv[r][c-1];
          end
          if (r == 0) begin
            b_pd[r][c] <= b_head_d[c];
            b_pv[r][c] <= b_head_v[c];
          end else begin
            b_pd[r][c] <= b_pd[r-1][c];
            b_pv[r][c] <= b_pv[r-1][c];
          end
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        mul[r][c] = $signed(a_pd[r][c]) * $signed(b_pd[r][c]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0;
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (clear_acc) begin
            acc[r*COLS+c] <= '0;
          end else if (a_pv[r][c] && b_pv[r][c]) begin
            acc[r*COLS+c] <= acc[r*COLS+c] + ACC_W'(mul[r][c]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if ({1'b0, rd_index} < (IW+1)'(N)) begin
      rd_data <= acc[rd_index];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_sys_arr_tile.sv
// tb/tb_sys_arr_tile.sv - self-checking bench for sys_arr_tile (4x4, DW=16, ACC_W=32)
module tb_sys_arr_tile;

  logic        clk;
  logic        rst;
  logic        start;
  logic        acc_keep;
  logic        busy;
  logic        done;
  logic [3:0]  rd_index;
  logic [31:0] rd_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          ta [8][4];
  int          tb [8][4];
  logic [31:0] model [16];

  sys_arr_tile_if #(.ROWS(4), .COLS(4), .DW(16)) sif ();

  sys_arr_tile #(.ROWS(4), .COLS(4), .DW(16), .ACC_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .acc_keep (acc_keep),
    .stream   (sif.slave),
    .busy     (busy),
    .done     (done),
    .rd_index (rd_index),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tiles();
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 4; j++) begin
        ta[k][j] = 0;
        tb[k][j] = 0;
      end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_index = 4'(i);
      tick();
      total++;
      if (rd_data !== model[i]) begin
        bad++;
        $display("FAIL %s rd[%0d] got=%h exp=%h", tag, i, rd_data, model[i]);
      end
    end
  endtask

  // gaps: 0 none, 1 alternate, 2 random. poke: pulse start during drain.
  task automatic run_tile(input string tag, input bit keep, input int k, input int gaps, input bit poke);
    int e_last;
    int n;
    logic signed [63:0] p;
    start = 1'b1;
    acc_keep = keep;
    tick();
    start = 1'b0;
    if (!keep) for (int i = 0; i < 16; i++) model[i] = '0;
    total++;
    if (busy !== 1'b1 || sif.in_ready !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s run_entry busy=%b ready=%b done=%b exp 1 1 0", tag, busy, sif.in_ready, done);
    end
    for (int b = 0; b < k; b++) begin
      if (gaps == 1 || (gaps == 2 && $urandom_range(1, 0) == 1)) begin
        sif.in_valid = 1'b0;
        sif.in_last  = 1'b1;
        tick();
        total++;
        if (sif.in_ready !== 1'b1 || busy !== 1'b1) begin
          bad++;
          $display("FAIL %s ready_in_gap got=%b exp=1", tag, sif.in_ready);
        end
      end
      sif.in_valid = 1'b1;
      sif.in_last  = (b == k - 1);
      for (int j = 0; j < 4; j++) begin
        sif.a_in[j*16 +: 16] = 16'(ta[b][j]);
        sif.b_in[j*16 +: 16] = 16'(tb[b][j]);
      end
      tick();
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          p = 64'(ta[b][r]) * 64'(tb[b][c]);
          model[r*4+c] = model[r*4+c] + p[31:0];
        end
    end
    sif.in_valid = 1'b0;
    sif.in_last  = 1'b0;
    e_last = cyc;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      start = poke && (n == 2);
      acc_keep = 1'b0;
      tick();
      start = 1'b0;
      n++;
    end
    total++;
    if (done !== 1'b1 || (cyc - e_last) != 8) begin
      bad++;
      $display("FAIL %s done_latency got=%0d done=%b exp=8", tag, cyc - e_last, done);
    end
    read_all(tag);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || sif.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s done_hold done=%b busy=%b ready=%b exp 1 0 0", tag, done, busy, sif.in_ready);
    end
  endtask

  task automatic load_small();
    clear_tiles();
    ta[0][0] = 1; ta[0][1] = 3; ta[1][0] = 2; ta[1][1] = 4;
    tb[0][0] = 5; tb[0][1] = 6; tb[1][0] = 7; tb[1][1] = 8;
  endtask

  task automatic load_identity();
    clear_tiles();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) begin
        ta[k][j] = (j == k) ? 1 : 0;
        tb[k][j] = k * 4 + j;
      end
  endtask

  task automatic test_reset();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sif.in_ready !== 1'b0 || rd_data !== 32'd0) begin
      bad++;
      $display("FAIL reset busy=%b done=%b ready=%b rd=%h exp all 0", busy, done, sif.in_ready, rd_data);
    end
    for (int i = 0; i < 16; i++) model[i] = '0;
    read_all("reset_acc");
  endtask

  task automatic test_small();
    load_small();
    run_tile("small", 1'b0, 2, 0, 1'b0);
    total++;
    if (model[0] !== 32'd19 || model[1] !== 32'd22 || model[4] !== 32'd43 || model[5] !== 32'd50) begin
      bad++;
      $display("FAIL small_ref got=%0d,%0d,%0d,%0d exp=19,22,43,50", model[0], model[1], model[4], model[5]);
    end
  endtask

  task automatic test_identity();
    load_identity();
    run_tile("identity", 1'b0, 4, 0, 1'b0);
  endtask

  task automatic test_bubbles();
    load_identity();
    run_tile("bubbles", 1'b0, 4, 1, 1'b0);
  endtask

  task automatic test_keep();
    load_identity();
    run_tile("keep_t1", 1'b0, 4, 0, 1'b0);
    run_tile("keep_t2", 1'b1, 4, 0, 1'b0);
    sif.in_valid = 1'b1;
    sif.in_last  = 1'b1;
    sif.a_in = '1;
    sif.b_in = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (sif.in_ready !== 1'b0 || done !== 1'b1) begin
        bad++;
        $display("FAIL keep_done_ready ready=%b done=%b exp 0 1", sif.in_ready, done);
      end
    end
    sif.in_valid = 1'b0;
    sif.in_last  = 1'b0;
    read_all("keep_after_done_beats");
    run_tile("keep_t3", 1'b0, 4, 0, 1'b0);
  endtask

  task automatic test_wrap();
    clear_tiles();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++) begin
        ta[k][j] = -32768;
        tb[k][j] = -32768;
      end
    run_tile("wrap", 1'b0, 3, 0, 1'b1);
    total++;
    if (model[15] !== 32'hC000_0000) begin
      bad++;
      $display("FAIL wrap_ref got=%h exp=c0000000", model[15]);
    end
    clear_tiles();
    for (int j = 0; j < 4; j++) begin
      ta[0][j] = -1;
      tb[0][j] = 1;
    end
    run_tile("neg_one", 1'b0, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic signed [15:0] v;
    int k;
    for (int t = 0; t < 6; t++) begin
      k = (t == 0) ? 1 : int'($urandom_range(6, 1));
      clear_tiles();
      for (int b = 0; b < k; b++)
        for (int j = 0; j < 4; j++) begin
          v = 16'($urandom);
          ta[b][j] = int'(v);
          v = 16'($urandom);
          tb[b][j] = int'(v);
        end
      run_tile($sformatf("random%0d", t), (t > 1) && $urandom_range(1, 0) == 1, k, 2, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    acc_keep = 1'b0;
    tick();
    start = 1'b0;
    sif.in_valid = 1'b1;
    sif.a_in = {4{16'd3}};
    sif.b_in = {4{16'd5}};
    tick();
    tick();
    sif.in_valid = 1'b0;
    rd_index = 4'd0;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sif.in_ready !== 1'b0 || rd_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid busy=%b done=%b ready=%b rd=%h exp all 0", busy, done, sif.in_ready, rd_data);
    end
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) model[i] = '0;
    read_all("reset_mid_acc");
    load_small();
    run_tile("rerun_small", 1'b0, 2, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    acc_keep = 1'b0;
    rd_index = 4'd0;
    sif.in_valid = 1'b0;
    sif.in_last = 1'b0;
    sif.a_in = '0;
    sif.b_in = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    test_reset();
    test_small();
    test_identity();
    test_bubbles();
    test_keep();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
